axi_slave_wr_arbiter: RTL and testbench

//  Per-slave write-channel arbiter for the AXI interconnect. Shares one slave port's AW/W

---
 rtl/axi_slave_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_axi_slave_wr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_arbiter.sv
// Per-slave AW/W round-robin arbiter with outstanding-burst cap.
// Drives handshakes only; payload muxing is selected by GRANT_ID.
module axi_slave_wr_arbiter #(
    parameter int M_WIDTH = 2,
    parameter int MAX_OST = 4,
    parameter int OST_W   = 3
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic [(2**M_WIDTH)-1:0] M_AWVALID,
    output logic [(2**M_WIDTH)-1:0] M_AWREADY,
    input  logic [(2**M_WIDTH)-1:0] M_WVALID,
    input  logic [(2**M_WIDTH)-1:0] M_WLAST,
    output logic [(2**M_WIDTH)-1:0] M_WREADY,
    output logic                     S_AWVALID,
    input  logic                     S_AWREADY,
    output logic                     S_WVALID,
    output logic                     S_WLAST,
    input  logic                     S_WREADY,
    input  logic                     S_BVALID,
    input  logic                     S_BREADY,
    output logic [M_WIDTH-1:0]       GRANT_ID,
    output logic [OST_W-1:0]         OST_CNT,
    output logic                     OST_ERR
);

    localparam int NM = 2 ** M_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_e;

    state_e             state_q, state_d;
    logic [M_WIDTH-1:0] grant_q, grant_d;
    logic [M_WIDTH-1:0] rr_q, rr_d;
    logic [OST_W-1:0]   ost_q, ost_d;
    logic               err_q, err_d;

    logic               found;
    logic [M_WIDTH-1:0] pick;
    logic [M_WIDTH-1:0] idx;
    logic               aw_hs;
    logic               b_hs;

    // First requester at or after the pointer; M_WIDTH-bit add wraps mod NM
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int i = 0; i < NM; i++) begin
            idx = rr_q + M_WIDTH'(i);
            if (!found && M_AWVALID[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        S_WLAST   = 1'b0;
        M_AWREADY = '0;
        M_WREADY  = '0;
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        unique case (state_q)
            IDLE: begin
                if (found && (ost_q < OST_W'(MAX_OST))) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                S_AWVALID          = M_AWVALID[grant_q];
                M_AWREADY[grant_q] = S_AWREADY;
                if (S_AWVALID && S_AWREADY) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                S_WVALID          = M_WVALID[grant_q];
                S_WLAST           = M_WLAST[grant_q];
                M_WREADY[grant_q] = S_WREADY;
                if (S_WVALID && S_WREADY && S_WLAST) begin
                    state_d = IDLE;
                    rr_d    = grant_q + M_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign aw_hs = (state_q == ADDR) && S_AWVALID && S_AWREADY;
    assign b_hs  = S_BVALID && S_BREADY;

    // Simultaneous AW and B handshakes cancel out
    always_comb begin
        ost_d = ost_q;
        err_d = err_q;
        if (aw_hs && !b_hs) begin
            ost_d = ost_q + OST_W'(1);
        end else if (b_hs && !aw_hs) begin
            if (ost_q == '0) begin
                err_d = 1'b1;
            end else begin
                ost_d = ost_q - OST_W'(1);
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            ost_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            ost_q   <= ost_d;
            err_q   <= err_d;
        end
    end

    assign GRANT_ID = grant_q;
    assign OST_CNT  = ost_q;
    assign OST_ERR  = err_q;

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// Directed bench for axi_slave_wr_arbiter: vector table plus
// hand-written multi-cycle sequences.
module tb_axi_slave_wr_arbiter;

    logic       BUS_CLK;
    logic       BUS_RST;
    logic [3:0] M_AWVALID;
    logic [3:0] M_AWREADY;
    logic [3:0] M_WVALID;
    logic [3:0] M_WLAST;
    logic [3:0] M_WREADY;
    logic       S_AWVALID;
    logic       S_AWREADY;
    logic       S_WVALID;
    logic       S_WLAST;
    logic       S_WREADY;
    logic       S_BVALID;
    logic       S_BREADY;
    logic [1:0] GRANT_ID;
    logic [2:0] OST_CNT;
    logic       OST_ERR;

    axi_slave_wr_arbiter #(
        .M_WIDTH(2),
        .MAX_OST(4),
        .OST_W  (3)
    ) dut (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .M_AWVALID(M_AWVALID),
        .M_AWREADY(M_AWREADY),
        .M_WVALID (M_WVALID),
        .M_WLAST  (M_WLAST),
        .M_WREADY (M_WREADY),
        .S_AWVALID(S_AWVALID),
        .S_AWREADY(S_AWREADY),
        .S_WVALID (S_WVALID),
        .S_WLAST  (S_WLAST),
        .S_WREADY (S_WREADY),
        .S_BVALID (S_BVALID),
        .S_BREADY (S_BREADY),
        .GRANT_ID (GRANT_ID),
        .OST_CNT  (OST_CNT),
        .OST_ERR  (OST_ERR)
    );

    typedef struct {
        logic [3:0] awv;
        logic [3:0] wv;
        logic [3:0] wl;
        logic       awr;
        logic       wr;
        logic       b;
        logic [3:0] e_awr;
        logic [3:0] e_wr;
        logic       e_sawv;
        logic       e_swv;
        logic       e_swl;
        logic [1:0] e_gid;
        logic [2:0] e_ost;
    } vec_t;

    vec_t vt[15];
    int   vectors;
    int   miscompares;

    initial begin
        BUS_CLK = 1'b0;
        forever #5 BUS_CLK = ~BUS_CLK;
    end

    function automatic vec_t mk(
        input logic [3:0] e_awr,
        input logic [3:0] e_wr,
        input logic       e_sawv,
        input logic       e_swv,
        input logic       b,
        input logic [1:0] e_gid,
        input logic [2:0] e_ost
    );
        vec_t v;
        v.awv    = 4'hF;
        v.wv     = 4'hF;
        v.wl     = 4'hF;
        v.awr    = 1'b1;
        v.wr     = 1'b1;
        v.b      = b;
        v.e_awr  = e_awr;
        v.e_wr   = e_wr;
        v.e_sawv = e_sawv;
        v.e_swv  = e_swv;
        v.e_swl  = e_swv;
        v.e_gid  = e_gid;
        v.e_ost  = e_ost;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic do_reset();
        M_AWVALID = '0;
        M_WVALID  = '0;
        M_WLAST   = '0;
        S_AWREADY = 1'b0;
        S_WREADY  = 1'b0;
        S_BVALID  = 1'b0;
        S_BREADY  = 1'b0;
        BUS_RST   = 1'b1;
        tick();
        tick();
        BUS_RST = 1'b0;
    endtask

    task automatic set_b(input logic b);
        S_BVALID = b;
        S_BREADY = b;
    endtask

    initial begin
        int         awc;
        int         beat;
        int         whs;
        int         lasts;
        logic [7:0] wr_pat;

        vectors     = 0;
        miscompares = 0;

        // Round-robin 0,1,2,3,0 with 1-beat bursts, B in each DATA cycle
        vt[0]  = mk(4'h0, 4'h0, 0, 0, 0, 2'd0, 3'd0);
        vt[1]  = mk(4'h1, 4'h0, 1, 0, 0, 2'd0, 3'd0);
        vt[2]  = mk(4'h0, 4'h1, 0, 1, 1, 2'd0, 3'd1);
        vt[3]  = mk(4'h0, 4'h0, 0, 0, 0, 2'd0, 3'd0);
        vt[4]  = mk(4'h2, 4'h0, 1, 0, 0, 2'd1, 3'd0);
        vt[5]  = mk(4'h0, 4'h2, 0, 1, 1, 2'd1, 3'd1);
        vt[6]  = mk(4'h0, 4'h0, 0, 0, 0, 2'd1, 3'd0);
        vt[7]  = mk(4'h4, 4'h0, 1, 0, 0, 2'd2, 3'd0);
        vt[8]  = mk(4'h0, 4'h4, 0, 1, 1, 2'd2, 3'd1);
        vt[9]  = mk(4'h0, 4'h0, 0, 0, 0, 2'd2, 3'd0);
        vt[10] = mk(4'h8, 4'h0, 1, 0, 0, 2'd3, 3'd0);
        vt[11] = mk(4'h0, 4'h8, 0, 1, 1, 2'd3, 3'd1);
        vt[12] = mk(4'h0, 4'h0, 0, 0, 0, 2'd3, 3'd0);
        vt[13] = mk(4'h1, 4'h0, 1, 0, 0, 2'd0, 3'd0);
        vt[14] = mk(4'h0, 4'h1, 0, 1, 1, 2'd0, 3'd1);

        BUS_RST = 1'b1;
        do_reset();
        #2;
        chk("rst_sawv", S_AWVALID, 0);
        chk("rst_swv", S_WVALID, 0);
        chk("rst_gid", GRANT_ID, 0);
        chk("rst_ost", OST_CNT, 0);
        chk("rst_err", OST_ERR, 0);

        for (int i = 0; i < 15; i++) begin
            M_AWVALID = vt[i].awv;
            M_WVALID  = vt[i].wv;
            M_WLAST   = vt[i].wl;
            S_AWREADY = vt[i].awr;
            S_WREADY  = vt[i].wr;
            set_b(vt[i].b);
            #2;
            chk($sformatf("v%0d_awr", i), M_AWREADY, vt[i].e_awr);
            chk($sformatf("v%0d_wr", i), M_WREADY, vt[i].e_wr);
            chk($sformatf("v%0d_sawv", i), S_AWVALID, vt[i].e_sawv);
            chk($sformatf("v%0d_swv", i), S_WVALID, vt[i].e_swv);
            chk($sformatf("v%0d_swl", i), S_WLAST, vt[i].e_swl);
            chk($sformatf("v%0d_gid", i), GRANT_ID, vt[i].e_gid);
            chk($sformatf("v%0d_ost", i), OST_CNT, vt[i].e_ost);
            tick();
        end
        chk("t1_err", OST_ERR, 0);

        // M1 4-beat burst with slave W stalls
        do_reset();
        M_AWVALID = 4'b0010;
        #2;
        chk("t2_idle_sawv", S_AWVALID, 0);
        tick();
        chk("t2_gid", GRANT_ID, 1);
        S_AWREADY = 1'b1;
        #2;
        chk("t2_sawv", S_AWVALID, 1);
        chk("t2_awr", M_AWREADY, 4'b0010);
        tick();
        M_AWVALID = '0;
        S_AWREADY = 1'b0;
        M_WVALID  = 4'b0010;
        wr_pat    = 8'b11001001;
        beat      = 0;
        whs       = 0;
        lasts     = 0;
        for (int c = 0; c < 8; c++) begin
            S_WREADY = wr_pat[c];
            M_WLAST  = (beat == 3) ? 4'b0010 : 4'b0000;
            #2;
            chk("t2_swv", S_WVALID, 1);
            chk("t2_swl", S_WLAST, (beat == 3));
            chk("t2_wr", M_WREADY, wr_pat[c] ? 4'b0010 : 4'b0000);
            if (S_WVALID && S_WREADY) begin
                whs++;
                if (S_WLAST) lasts++;
            end
            if (wr_pat[c]) beat++;
            tick();
        end
        S_WREADY = 1'b1;
        #2;
        chk("t2_whs", whs, 4);
        chk("t2_lasts", lasts, 1);
        chk("t2_idle_swv", S_WVALID, 0);
        chk("t2_idle_wr", M_WREADY, 0);
        tick();

        // Outstanding cap: M0 keeps requesting, no B
        do_reset();
        M_AWVALID = 4'b0001;
        M_WVALID  = 4'b0001;
        M_WLAST   = 4'b0001;
        S_AWREADY = 1'b1;
        S_WREADY  = 1'b1;
        awc       = 0;
        for (int c = 0; c < 16; c++) begin
            #2;
            if (S_AWVALID && S_AWREADY) awc++;
            tick();
        end
        #2;
        chk("t3_awc", awc, 4);
        chk("t3_ost4", OST_CNT, 4);
        chk("t3_held", S_AWVALID, 0);
        S_AWREADY = 1'b0;
        set_b(1'b1);
        tick();
        set_b(1'b0);
        #2;
        chk("t3_ost3", OST_CNT, 3);
        chk("t3_sawv_n1", S_AWVALID, 0);
        tick();
        #2;
        chk("t3_sawv_n2", S_AWVALID, 1);
        chk("t3_gid", GRANT_ID, 0);

        // AW and B in the same cycle at OST_CNT==2
        set_b(1'b1);
        tick();
        set_b(1'b0);
        #2;
        chk("t4_ost2", OST_CNT, 2);
        chk("t4_in_addr", S_AWVALID, 1);
        S_AWREADY = 1'b1;
        set_b(1'b1);
        tick();
        S_AWREADY = 1'b0;
        set_b(1'b0);
        #2;
        chk("t4_ost_same", OST_CNT, 2);
        chk("t4_in_data", S_WVALID, 1);
        tick();

        // Reset mid-burst
        M_WLAST = 4'b0000;
        tick();
        S_AWREADY = 1'b1;
        tick();
        S_AWREADY = 1'b0;
        #2;
        chk("t5_in_data", S_WVALID, 1);
        chk("t5_ost3", OST_CNT, 3);
        tick();
        BUS_RST = 1'b1;
        tick();
        BUS_RST   = 1'b0;
        M_AWVALID = 4'b1010;
        S_AWREADY = 1'b1;
        #2;
        chk("t5_sawv", S_AWVALID, 0);
        chk("t5_swv", S_WVALID, 0);
        chk("t5_swl", S_WLAST, 0);
        chk("t5_awr", M_AWREADY, 0);
        chk("t5_wr", M_WREADY, 0);
        chk("t5_ost", OST_CNT, 0);
        chk("t5_gid", GRANT_ID, 0);
        tick();
        #2;
        chk("t5_new_gid", GRANT_ID, 1);
        chk("t5_new_sawv", S_AWVALID, 1);
        chk("t5_new_awr", M_AWREADY, 4'b0010);

        // B with nothing outstanding
        do_reset();
        set_b(1'b1);
        tick();
        set_b(1'b0);
        #2;
        chk("t6_ost", OST_CNT, 0);
        chk("t6_err", OST_ERR, 1);
        tick();
        tick();
        tick();
        chk("t6_sticky", OST_ERR, 1);
        do_reset();
        #2;
        chk("t6_cleared", OST_ERR, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
